iterative_multiplier: RTL and testbench

ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_negate.sv | 20 ++
 rtl/iterative_multiplier.sv | 132 +++++++++++++
 tb/tb_iterative_multiplier.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative multiplier:
//   DEFAULT_DATA_WIDTH - default operand width in bits
//   mult_state_t       - controller state encoding (IDLE / CALC / DONE)
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/mult_negate.sv
// ---------------------------------------------------------------------------
// mult_negate
// Conditional two's-complement negate of a WIDTH-bit value.
// Used for operand magnitudes and for the final sign fix of the product.
// Ports:
//   din  [WIDTH-1:0]  value in
//   neg               1 = output -din, 0 = output din
//   dout [WIDTH-1:0]  result (modulo 2^WIDTH)
// ---------------------------------------------------------------------------
module mult_negate #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule : mult_negate

// File: rtl/iterative_multiplier.sv
// ---------------------------------------------------------------------------
// iterative_multiplier
// Radix-2 shift-add multiplier, one partial product per clock.
// Accepts operands in IDLE, spends data_width cycles in CALC, then holds the
// 2*data_width product in DONE until the consumer takes it.
//
// Build option: MULT_SIGNED_EN
//   defined   - signed_mode=1 treats A/B as two's complement (sign-magnitude
//               multiply with a final negate)
//   undefined - no sign logic; signed_mode is ignored, all products unsigned
//
// Ports:
//   clk, rst            clock, async active-high reset
//   A, B                multiplicand / multiplier (data_width bits)
//   signed_mode         operand interpretation, sampled with A/B
//   in_valid, in_ready  operand handshake (ready only in IDLE)
//   product             result (2*data_width bits), valid with out_valid
//   out_valid,out_ready result handshake (valid only in DONE)
// ---------------------------------------------------------------------------
module iterative_multiplier
    import mult_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [data_width-1:0]   A,
    input  logic [data_width-1:0]   B,
    input  logic                    signed_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2*data_width-1:0] product,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int PW    = 2 * data_width;
    localparam int CNT_W = $clog2(data_width + 1);

    mult_state_t             state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [PW-1:0]           acc, mcand, acc_next, prod_fixed;
    logic [data_width-1:0]   mplier, mag_a, mag_b;
    logic                    last_step;

    assign last_step = (cnt == CNT_W'(1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

`ifdef MULT_SIGNED_EN
    logic neg_a, neg_b, neg_res;

    assign neg_a = signed_mode & A[data_width-1];
    assign neg_b = signed_mode & B[data_width-1];

    // |x| as an unsigned data_width value: most-negative maps to 2^(w-1)
    mult_negate #(.WIDTH(data_width)) u_abs_a (.din(A), .neg(neg_a), .dout(mag_a));
    mult_negate #(.WIDTH(data_width)) u_abs_b (.din(B), .neg(neg_b), .dout(mag_b));
    // Sign fix applied to the final accumulation so the product register
    // is already correct on the edge that enters DONE
    mult_negate #(.WIDTH(PW)) u_fix (.din(acc_next), .neg(neg_res), .dout(prod_fixed));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            neg_res <= 1'b0;
        else if (state == IDLE && in_valid)
            neg_res <= neg_a ^ neg_b;
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign mag_a      = A;
    assign mag_b      = B;
    assign prod_fixed = acc_next;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: multiplicand shifts left, multiplier shifts right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= CNT_W'(data_width);
                        acc    <= '0;
                        mcand  <= {{data_width{1'b0}}, mag_a};
                        mplier <= mag_b;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (last_step)
                        product <= prod_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule : iterative_multiplier

// File: tb/tb_iterative_multiplier.sv
// ---------------------------------------------------------------------------
// tb_iterative_multiplier
// Directed checks of the iterative multiplier at data_width=4: products in
// both modes, latency, backpressure hold, input isolation after accept, and
// reset in the middle of a calculation. Expected values for signed_mode=1
// follow the MULT_SIGNED_EN build option.
// ---------------------------------------------------------------------------
module tb_iterative_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   a, b;
    logic           signed_mode;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] product;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    iterative_multiplier #(.data_width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a),
        .B          (b),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .product    (product),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold cycles of out_ready=0 after out_valid rises.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sm, input logic [2*W-1:0] exp, input int hold);
        int k;
        logic [2*W-1:0] seen;
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after accept; result must not change
        in_valid = 1'b0; a = ~av; b = ~bv; signed_mode = ~sm;
        check({tag, "_busy"}, 32'({in_ready, out_valid}), 32'd0);
        k = 0;
        while (!out_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(W));
        check({tag, "_product"}, 32'(product), 32'(exp));
        seen = product;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold"}, 32'({out_valid, in_ready, product}), 32'({1'b1, 1'b0, seen}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int bad_valid;
        rst = 1'b1; a = '0; b = '0; signed_mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_product", 32'(product), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Backpressure on the first op
        run_op("u_1000x1111", 4'b1000, 4'b1111, 1'b0, 8'h78, 5);
        run_op("u_1111x1111", 4'b1111, 4'b1111, 1'b0, 8'hE1, 0);
        run_op("u_1001x0011", 4'b1001, 4'b0011, 1'b0, 8'h1B, 0);
        run_op("u_0011x0101", 4'b0011, 4'b0101, 1'b0, 8'h0F, 0);
        run_op("s_0011x0101", 4'b0011, 4'b0101, 1'b1, 8'h0F, 0);
        run_op("u_zero",      4'b0000, 4'b1011, 1'b0, 8'h00, 0);
`ifdef MULT_SIGNED_EN
        run_op("s_1000x1111", 4'b1000, 4'b1111, 1'b1, 8'h08, 2);
        run_op("s_1111x1111", 4'b1111, 4'b1111, 1'b1, 8'h01, 0);
        run_op("s_1001x0011", 4'b1001, 4'b0011, 1'b1, 8'hEB, 0);
        run_op("s_zero",      4'b0000, 4'b1001, 1'b1, 8'h00, 0);
`else
        // Sign handling not built: signed_mode is ignored
        run_op("s_1000x1111", 4'b1000, 4'b1111, 1'b1, 8'h78, 2);
        run_op("s_1111x1111", 4'b1111, 4'b1111, 1'b1, 8'hE1, 0);
        run_op("s_1001x0011", 4'b1001, 4'b0011, 1'b1, 8'h1B, 0);
`endif

        // Reset two edges into CALC
        @(negedge clk);
        a = 4'b1001; b = 4'b0011; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_product", 32'(product), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        bad_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad_valid++;
        end
        check("rst_mid_no_emit", 32'(bad_valid), 32'd0);
        run_op("after_rst", 4'b0011, 4'b0101, 1'b0, 8'h0F, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_iterative_multiplier
